// File: rtl/led_breath_pwm.sv
// LED breathing PWM driver.
// Consumes a 1 us tick and drives one LED through a repeating cycle:
// ramp up, hold bright, ramp down, hold dark. The duty level changes only
// at PWM period boundaries, so a period never changes its duty part-way.
module led_breath_pwm #(
    parameter int PWM_W    = 8,
    parameter int STEP_INC = 1,
    parameter int STEP_PER = 4,
    parameter int HOLD_PER = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_us_tick,
    input  logic             i_enable,
    output logic             o_led_out,
    output logic [PWM_W-1:0] o_level,
    output logic [2:0]       o_phase,
    output logic             o_period_end
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam logic [PWM_W-1:0] LMAX       = '1;
    localparam logic [PWM_W-1:0] ONE_P      = PWM_W'(1);
    localparam logic [PWM_W:0]   LMAX_X     = {1'b0, LMAX};
    localparam logic [PWM_W:0]   INC_X      = (PWM_W + 1)'(STEP_INC);
    localparam logic [7:0]       STEP_PER_C = 8'(STEP_PER);
    localparam logic [7:0]       HOLD_PER_C = 8'(HOLD_PER);

    state_t           r_state;
    logic [PWM_W-1:0] r_level;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [7:0]       r_step_cnt;
    logic [7:0]       r_hold_cnt;
    logic             r_period_end;
    logic             r_led;

    state_t           w_state_next;
    logic [PWM_W-1:0] w_level_next;
    logic [PWM_W-1:0] w_pwm_next;
    logic [7:0]       w_step_next;
    logic [7:0]       w_hold_next;
    logic             w_pe_next;
    logic [PWM_W:0]   w_sum;
    logic [7:0]       w_step_inc;
    logic [7:0]       w_hold_inc;

    assign w_step_inc = r_step_cnt + 8'd1;
    assign w_hold_inc = r_hold_cnt + 8'd1;
    // Level+increment is formed one bit wider so the clamp to LMAX sees any carry.
    assign w_sum      = {1'b0, r_level} + INC_X;

    // Next-state logic: enable low dominates everything, then IDLE start-up,
    // then PWM counting with level/phase decisions only on the counter wrap.
    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        w_pwm_next   = r_pwm_cnt;
        w_step_next  = r_step_cnt;
        w_hold_next  = r_hold_cnt;
        w_pe_next    = 1'b0;
        if (!i_enable) begin
            w_state_next = IDLE;
            w_level_next = '0;
            w_pwm_next   = '0;
            w_step_next  = '0;
            w_hold_next  = '0;
        end else if (r_state == IDLE) begin
            // Start immediately, no tick required; the fresh ramp begins at 0.
            w_state_next = UP;
            w_level_next = '0;
            w_pwm_next   = '0;
            w_step_next  = '0;
            w_hold_next  = '0;
        end else if (i_us_tick) begin
            w_pwm_next = r_pwm_cnt + ONE_P;
            if (r_pwm_cnt == LMAX) begin
                w_pe_next = 1'b1;
                case (r_state)
                    UP: begin
                        if (w_step_inc >= STEP_PER_C) begin
                            w_step_next = '0;
                            if (w_sum >= LMAX_X) begin
                                w_level_next = LMAX;
                                w_state_next = HOLD_HI;
                                w_hold_next  = '0;
                            end else begin
                                w_level_next = w_sum[PWM_W-1:0];
                            end
                        end else begin
                            w_step_next = w_step_inc;
                        end
                    end
                    HOLD_HI: begin
                        if (w_hold_inc >= HOLD_PER_C) begin
                            w_hold_next  = '0;
                            w_step_next  = '0;
                            w_state_next = DOWN;
                        end else begin
                            w_hold_next = w_hold_inc;
                        end
                    end
                    DOWN: begin
                        if (w_step_inc >= STEP_PER_C) begin
                            w_step_next = '0;
                            if ({1'b0, r_level} > INC_X) begin
                                w_level_next = r_level - INC_X[PWM_W-1:0];
                            end else begin
                                // Clamp at zero instead of wrapping below it.
                                w_level_next = '0;
                                w_state_next = HOLD_LO;
                                w_hold_next  = '0;
                            end
                        end else begin
                            w_step_next = w_step_inc;
                        end
                    end
                    HOLD_LO: begin
                        if (w_hold_inc >= HOLD_PER_C) begin
                            w_hold_next  = '0;
                            w_step_next  = '0;
                            w_state_next = UP;
                        end else begin
                            w_hold_next = w_hold_inc;
                        end
                    end
                    default: begin
                        w_state_next = IDLE;
                    end
                endcase
            end
        end
    end

    // State and counter registers; the LED compares against the level that
    // applies to the upcoming tick so a new level takes effect from tick 0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_level      <= '0;
            r_pwm_cnt    <= '0;
            r_step_cnt   <= '0;
            r_hold_cnt   <= '0;
            r_period_end <= 1'b0;
            r_led        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_level      <= w_level_next;
            r_pwm_cnt    <= w_pwm_next;
            r_step_cnt   <= w_step_next;
            r_hold_cnt   <= w_hold_next;
            r_period_end <= w_pe_next;
            r_led        <= i_enable && (w_pwm_next < w_level_next);
        end
    end

    assign o_led_out    = r_led;
    assign o_level      = r_level;
    assign o_phase      = r_state;
    assign o_period_end = r_period_end;

endmodule

// File: tb/tb_led_breath_pwm.sv
// Directed bench for led_breath_pwm with PWM_W=4, STEP_PER=1, HOLD_PER=2.
// A second instance with STEP_INC=6 shares all inputs to check clamping.
module tb_led_breath_pwm;

    logic       clk = 1'b0;
    logic       reset;
    logic       us_tick;
    logic       enable;
    logic       led_out, period_end;
    logic [3:0] level;
    logic [2:0] phase;
    logic       s_led_out, s_period_end;
    logic [3:0] s_level;
    logic [2:0] s_phase;

    int vectors = 0;
    int miscompares = 0;
    bit tick_on = 1'b0;
    bit sparse = 1'b0;
    int div = 0;
    int led_acc = 0;
    int prev_acc = 0;
    int n;

    always #5 clk = ~clk;

    led_breath_pwm #(.PWM_W(4), .STEP_INC(1), .STEP_PER(1), .HOLD_PER(2)) dut (
        .i_clk(clk), .i_reset(reset), .i_us_tick(us_tick), .i_enable(enable),
        .o_led_out(led_out), .o_level(level), .o_phase(phase), .o_period_end(period_end)
    );

    led_breath_pwm #(.PWM_W(4), .STEP_INC(6), .STEP_PER(1), .HOLD_PER(2)) dut_sat (
        .i_clk(clk), .i_reset(reset), .i_us_tick(us_tick), .i_enable(enable),
        .o_led_out(s_led_out), .o_level(s_level), .o_phase(s_phase), .o_period_end(s_period_end)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("  ok %s = %0d", tag, obs);
        end
    endtask

    // One clock: choose tick for this edge, then sample 1 time unit after it.
    task automatic cyc();
        if (sparse) begin
            us_tick = (div == 0);
            div = (div == 23) ? 0 : div + 1;
        end else begin
            us_tick = tick_on;
        end
        @(posedge clk);
        #1;
    endtask

    // Advance to the next period_end sample, accumulating LED-high samples.
    task automatic wait_pe(input int bound, output int cycles);
        cycles = 0;
        forever begin
            cyc();
            cycles++;
            if (period_end) begin
                prev_acc = led_acc;
                led_acc = int'(led_out);
                break;
            end
            led_acc += int'(led_out);
            if (cycles >= bound) begin
                check_eq("pe_timeout", int'(period_end), 1);
                break;
            end
        end
    endtask

    int sat_lvl[10] = '{6, 12, 15, 15, 15, 9, 3, 0, 0, 0};
    int sat_ph[10]  = '{1, 1, 2, 2, 3, 3, 3, 4, 4, 1};

    initial begin
        int exp_lvl, exp_ph;
        reset = 1'b1; enable = 1'b0; us_tick = 1'b0;
        repeat (3) cyc();
        check_eq("rst_led", int'(led_out), 0);
        check_eq("rst_level", int'(level), 0);
        check_eq("rst_phase", int'(phase), 0);
        check_eq("rst_pe", int'(period_end), 0);

        // Start without any tick: UP on the next clock.
        reset = 1'b0; enable = 1'b1;
        cyc();
        check_eq("start_phase", int'(phase), 1);
        check_eq("start_level", int'(level), 0);

        // Run to level 7, then reset asynchronously between edges.
        tick_on = 1'b1;
        repeat (7) wait_pe(40, n);
        check_eq("pre_rst_level", int'(level), 7);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_led", int'(led_out), 0);
        check_eq("arst_level", int'(level), 0);
        check_eq("arst_phase", int'(phase), 0);
        check_eq("arst_pe", int'(period_end), 0);
        repeat (2) cyc();
        check_eq("rst_hold_level", int'(level), 0);
        reset = 1'b0;
        cyc();
        check_eq("rerun_phase", int'(phase), 1);
        check_eq("rerun_level", int'(level), 0);

        // Full breathing cycle: 15 up, 2 hold, 15 down, 2 hold = 34 periods.
        led_acc = int'(led_out);
        for (int k = 1; k <= 34; k++) begin
            wait_pe(40, n);
            check_eq($sformatf("pe%0d_gap", k), n, 16);
            if (k <= 15) begin
                exp_lvl = k;            exp_ph = (k == 15) ? 2 : 1;
            end else if (k == 16) begin
                exp_lvl = 15;           exp_ph = 2;
            end else if (k == 17) begin
                exp_lvl = 15;           exp_ph = 3;
            end else if (k <= 32) begin
                exp_lvl = 32 - k;       exp_ph = (k == 32) ? 4 : 3;
            end else begin
                exp_lvl = 0;            exp_ph = (k == 34) ? 1 : 4;
            end
            check_eq($sformatf("pe%0d_level", k), int'(level), exp_lvl);
            check_eq($sformatf("pe%0d_phase", k), int'(phase), exp_ph);
            if (k <= 10) begin
                check_eq($sformatf("sat%0d_level", k), int'(s_level), sat_lvl[k-1]);
                check_eq($sformatf("sat%0d_phase", k), int'(s_phase), sat_ph[k-1]);
            end
            if (k == 6)  check_eq("duty_lvl5", prev_acc, 5);
            if (k == 16) check_eq("duty_lvl15", prev_acc, 15);
            if (k == 34) check_eq("duty_lvl0", prev_acc, 0);
        end

        // Drop enable on the edge where the level would step from 8 to 9.
        repeat (8) wait_pe(40, n);
        check_eq("pre_drop_level", int'(level), 8);
        repeat (15) cyc();
        check_eq("pre_drop_pe", int'(period_end), 0);
        enable = 1'b0;
        cyc();
        check_eq("drop_phase", int'(phase), 0);
        check_eq("drop_level", int'(level), 0);
        check_eq("drop_led", int'(led_out), 0);
        check_eq("drop_pe", int'(period_end), 0);
        check_eq("drop_sat_phase", int'(s_phase), 0);
        repeat (3) cyc();
        check_eq("idle_level", int'(level), 0);

        // Re-enable with one tick every 24 clocks.
        sparse = 1'b1; div = 0; enable = 1'b1;
        cyc();
        check_eq("reen_phase", int'(phase), 1);
        check_eq("reen_level", int'(level), 0);
        wait_pe(1000, n);
        check_eq("sparse_lvl1", int'(level), 1);
        wait_pe(1000, n);
        check_eq("sparse_gap", n, 384);
        check_eq("sparse_lvl2", int'(level), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
